// File: rtl/filter_pkg.sv
// Shared filter definitions: load FSM state encoding and memory geometry
// derived from the global MEM_SIZE / BUS_SIZE / CHANNEL_NUM / COMPUTE_UNIT_NUM
// macros. Used by the filter loader and by the filter memory.

`ifndef MEM_SIZE
`define MEM_SIZE 32
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef CHANNEL_NUM
`define CHANNEL_NUM 8
`endif
`ifndef COMPUTE_UNIT_NUM
`define COMPUTE_UNIT_NUM 2
`endif

package filter_pkg;

   // Beats per chunk and number of chunks held by the filter memory.
   localparam int PARAM_WR_DAT_CYC_NUM = `MEM_SIZE / `BUS_SIZE;
   localparam int SRAM_FILTER_NUM      = (`MEM_SIZE / `CHANNEL_NUM) * `COMPUTE_UNIT_NUM;

   localparam int BUS_BYTES   = `BUS_SIZE;
   localparam int DAT_CNT_W   = $clog2(PARAM_WR_DAT_CYC_NUM);
   localparam int CHUNK_CNT_W = $clog2(SRAM_FILTER_NUM);
   localparam int BUS_IDX_W   = $clog2(BUS_BYTES);
   localparam int POP_W       = $clog2(BUS_BYTES + 1);

   localparam logic [DAT_CNT_W-1:0]   DAT_CNT_LAST = DAT_CNT_W'(PARAM_WR_DAT_CYC_NUM - 1);
   localparam logic [DAT_CNT_W-1:0]   DAT_ONE      = DAT_CNT_W'(1);
   localparam logic [CHUNK_CNT_W-1:0] CHUNK_ONE    = CHUNK_CNT_W'(1);
   localparam logic [BUS_IDX_W-1:0]   BUS_IDX_ONE  = BUS_IDX_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } filter_state_e;

   // Number of zero bytes in a beat, given its sparsity map.
   function automatic logic [POP_W-1:0] count_zero_bytes(input logic [BUS_BYTES-1:0] sparsemap);
      logic [POP_W-1:0] cnt;
      cnt = '0;
      for (int k = 0; k < BUS_BYTES; k++) begin
         if (!sparsemap[k]) begin
            cnt = cnt + POP_W'(1);
         end else begin
            cnt = cnt;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/filter_loader_sparse_compressor.sv
// Sparse_Compressor: combinational compaction of one dense filter beat into a
// nonzero-byte bitmap plus the nonzero bytes packed toward index 0, with the
// unused upper slots forced to zero.

module sparse_compressor
   import filter_pkg::*;
(
   input  logic [BUS_BYTES-1:0][7:0] data_i,
   output logic [BUS_BYTES-1:0]      sparsemap_o,
   output logic [BUS_BYTES-1:0][7:0] nonzero_data_o
);

   // Walk bytes in ascending order, dropping each nonzero byte into the next free slot.
   always_comb begin
      logic [BUS_IDX_W-1:0] slot_s;
      sparsemap_o    = '0;
      nonzero_data_o = '0;
      slot_s         = '0;
      for (int k = 0; k < BUS_BYTES; k++) begin
         if (data_i[k] != 8'h00) begin
            sparsemap_o[k]         = 1'b1;
            nonzero_data_o[slot_s] = data_i[k];
            slot_s                 = slot_s + BUS_IDX_ONE;
         end else begin
            sparsemap_o[k] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/filter_loader.sv
// filter_loader: accepts dense filter beats over a valid/ready stream,
// compresses each beat and writes it to the filter memory with beat/chunk
// counts, for chunks 0..chunk_last latched at start.
// Optional build macro FILTER_LOADER_STATS_EN adds zero_cnt_o, a saturating
// count of zero bytes seen across the accepted beats of the current load.

module filter_loader
   import filter_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic [CHUNK_CNT_W-1:0]    chunk_last_i,
   input  logic [BUS_BYTES-1:0][7:0] in_data_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   output logic [BUS_BYTES-1:0]      wr_sparsemap_o,
   output logic [BUS_BYTES-1:0][7:0] wr_nonzero_data_o,
   output logic                      wr_valid_o,
   output logic [DAT_CNT_W-1:0]      wr_dat_count_o,
   output logic [CHUNK_CNT_W-1:0]    wr_chunk_count_o,
   output logic                      busy_o,
   output logic                      done_o
`ifdef FILTER_LOADER_STATS_EN
   ,
   output logic [31:0]               zero_cnt_o
`endif
);

   filter_state_e            state_q, state_d;
   logic [DAT_CNT_W-1:0]     dat_cnt_q, dat_cnt_d;
   logic [CHUNK_CNT_W-1:0]   chunk_cnt_q, chunk_cnt_d;
   logic [CHUNK_CNT_W-1:0]   chunk_last_q, chunk_last_d;

   logic                     accept_s;
   logic [BUS_BYTES-1:0]     sparsemap_s;
   logic [BUS_BYTES-1:0][7:0] nonzero_s;

   logic                     wr_valid_q;
   logic [BUS_BYTES-1:0]     wr_sparsemap_q;
   logic [BUS_BYTES-1:0][7:0] wr_nonzero_q;
   logic [DAT_CNT_W-1:0]     wr_dat_q;
   logic [CHUNK_CNT_W-1:0]   wr_chunk_q;

   // Ready depends on state alone so the upstream can never form a loop through it.
   assign accept_s   = in_valid_i & (state_q == LOAD);
   assign in_ready_o = (state_q == LOAD);
   assign busy_o     = (state_q != IDLE);
   assign done_o     = (state_q == DONE);

   sparse_compressor u_compressor (
      .data_i         (in_data_i),
      .sparsemap_o    (sparsemap_s),
      .nonzero_data_o (nonzero_s)
   );

   // Next-state and counter update; the final chunk does not bump chunk_cnt so it never overflows.
   always_comb begin
      state_d      = state_q;
      dat_cnt_d    = dat_cnt_q;
      chunk_cnt_d  = chunk_cnt_q;
      chunk_last_d = chunk_last_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d      = LOAD;
               chunk_last_d = chunk_last_i;
               dat_cnt_d    = '0;
               chunk_cnt_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (accept_s) begin
               if (dat_cnt_q == DAT_CNT_LAST) begin
                  dat_cnt_d = '0;
                  if (chunk_cnt_q == chunk_last_q) begin
                     state_d = DONE;
                  end else begin
                     chunk_cnt_d = chunk_cnt_q + CHUNK_ONE;
                  end
               end else begin
                  dat_cnt_d = dat_cnt_q + DAT_ONE;
               end
            end else begin
               state_d = LOAD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and load counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         dat_cnt_q    <= '0;
         chunk_cnt_q  <= '0;
         chunk_last_q <= '0;
      end else begin
         state_q      <= state_d;
         dat_cnt_q    <= dat_cnt_d;
         chunk_cnt_q  <= chunk_cnt_d;
         chunk_last_q <= chunk_last_d;
      end
   end

   // Memory write port: one-cycle strobe per accepted beat, data and counts hold between strobes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_valid_q     <= 1'b0;
         wr_sparsemap_q <= '0;
         wr_nonzero_q   <= '0;
         wr_dat_q       <= '0;
         wr_chunk_q     <= '0;
      end else if (accept_s) begin
         wr_valid_q     <= 1'b1;
         wr_sparsemap_q <= sparsemap_s;
         wr_nonzero_q   <= nonzero_s;
         wr_dat_q       <= dat_cnt_q;
         wr_chunk_q     <= chunk_cnt_q;
      end else begin
         wr_valid_q <= 1'b0;
      end
   end

   assign wr_valid_o        = wr_valid_q;
   assign wr_sparsemap_o    = wr_sparsemap_q;
   assign wr_nonzero_data_o = wr_nonzero_q;
   assign wr_dat_count_o    = wr_dat_q;
   assign wr_chunk_count_o  = wr_chunk_q;

`ifdef FILTER_LOADER_STATS_EN
   logic [31:0] zero_cnt_q;
   logic [32:0] zero_sum_s;

   assign zero_sum_s = {1'b0, zero_cnt_q} + 33'(count_zero_bytes(sparsemap_s));

   // Zero-byte statistic, cleared per load and pinned at all-ones instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         zero_cnt_q <= 32'd0;
      end else if ((state_q == IDLE) && start_i) begin
         zero_cnt_q <= 32'd0;
      end else if (accept_s) begin
         zero_cnt_q <= zero_sum_s[32] ? 32'hFFFF_FFFF : zero_sum_s[31:0];
      end else begin
         zero_cnt_q <= zero_cnt_q;
      end
   end

   assign zero_cnt_o = zero_cnt_q;
`endif

endmodule
